io_peripheral_ctrl: RTL and testbench
=====================================

Name: io_peripheral_ctrl

Overview:
- External-side I/O controller at the far end of the CPU's port interface.
- Captures CPU output-port writes into a small TX FIFO and drains them to an external device over a valid/ready handshake.
- Accepts bytes from the external device into a holding register that drives the CPU input port.
- Raises the CPU interrupt line for each received byte, and holds off further input until the CPU acknowledges the read.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- INT_PULSE_CYC, 2, cycles int_sig stays high per received byte; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cpu_out_data  in  8  CPU O_Port value.
- cpu_out_we  in  1  CPU output write strobe (OUT instruction, IO_Write).
- cpu_in_data  out  8  byte presented to CPU I_Port.
- cpu_in_ack  in  1  CPU consumed cpu_in_data (IN executed); one-cycle pulse.
- int_sig  out  1  interrupt request to CPU.
- int_enable  in  1  1 = generate interrupts on receive.
- ext_tx_data  out  8  byte to external device.
- ext_tx_valid  out  1  ext_tx_data valid.
- ext_tx_ready  in  1  external device accepts.
- ext_rx_data  in  8  byte from external device.
- ext_rx_valid  in  1  ext_rx_data valid.
- ext_rx_ready  out  1  block can accept an rx byte.
- rx_full  out  1  holding register occupied (not yet acked).
- tx_overflow  out  1  sticky: a CPU write was dropped.

Behaviour:
- Reset (rstn=0, asynchronous):
  - FIFO empty; rx state S_EMPTY.
  - cpu_in_data=0, int_sig=0, ext_tx_valid=0, ext_tx_data=0, rx_full=0, tx_overflow=0.
  - ext_rx_ready=1.
  - Reset mid-transfer discards FIFO contents and any held rx byte.
- TX path:
  - FIFO with rd/wr pointers of width log2(FIFO_DEPTH)+1; full/empty from MSB compare.
  - pop = ext_tx_valid & ext_tx_ready.
  - push = cpu_out_we & (!full | pop). When full, a simultaneous pop frees a slot, so the write is accepted.
  - ext_tx_valid = !empty. ext_tx_data = head entry, registered.
  - Latency: a write into an empty FIFO at edge N gives ext_tx_valid=1 with that data after edge N.
  - Data must remain stable while valid & !ready.
  - cpu_out_we when full with no pop: byte dropped, tx_overflow set. tx_overflow clears only on reset.
  - Pointers wrap modulo 2*FIFO_DEPTH. Order is strictly FIFO.
- RX path, FSM with states S_EMPTY, S_IRQ, S_WAIT:
  - S_EMPTY:
    - ext_rx_ready=1.
    - On ext_rx_valid: latch ext_rx_data into cpu_in_data and set rx_full.
    - Then go to S_IRQ (cnt=0) if int_enable=1, else to S_WAIT.
  - S_IRQ:
    - int_sig=1 (registered, high starting the cycle after capture).
    - Increment cnt; after INT_PULSE_CYC cycles go to S_WAIT.
  - S_WAIT:
    - int_sig=0; wait for cpu_in_ack.
    - On ack: clear rx_full, go to S_EMPTY.
  - cpu_in_ack in S_IRQ: int_sig drops next cycle, rx_full clears, go to S_EMPTY.
  - cpu_in_ack in S_EMPTY: ignored.
  - ext_rx_ready=0 in S_IRQ and S_WAIT. External data is not overwritten; no rx overflow is possible.
  - After ack, the next byte can be captured no earlier than the cycle after returning to S_EMPTY.
  - cpu_in_data holds the last captured byte after ack; it is not cleared.
  - int_enable is sampled only at capture; changing it mid-pulse does not truncate the pulse.
- TX and RX paths are fully independent; simultaneous events on both act in the same cycle.

Decomposition:
- Package io_periph_pkg:
  - rx state encoding (S_EMPTY=2'd0, S_IRQ=2'd1, S_WAIT=2'd2);
  - data width constant 8;
  - pointer-width function clog2.
- Sub-module io_tx_fifo: parameterised synchronous FIFO with push/pop/full/empty, same clk/rstn. The top level holds the rx FSM, overflow flag and glue.

Test Plan:
- TX basic, ready=1: write 0x11, 0x22, 0x33 on consecutive cycles -> ext_tx_data shows 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its write; valid drops after 0x33.
- TX overflow, ready=0: write 0x01..0x05 with FIFO_DEPTH=4 -> 0x05 dropped, tx_overflow=1. Raise ready -> 0x01..0x04 emerge in order; tx_overflow stays 1.
- TX full plus simultaneous pop: FIFO full, same cycle ready=1 and write 0xAA -> 0xAA accepted, tx_overflow stays 0, 0xAA emerges last.
- RX with interrupt, int_enable=1, INT_PULSE_CYC=2:
  - ext_rx_valid with 0x5C -> cpu_in_data=0x5C and ext_rx_ready=0.
  - int_sig high exactly 2 cycles.
  - ack -> rx_full=0, ext_rx_ready=1 next cycle.
- RX back-pressure and early ack: while S_WAIT, hold ext_rx_valid with 0x77 -> not captured until after ack; ack during S_IRQ truncates int_sig to 1 cycle.
- Reset mid-operation: FIFO holding 3 bytes and rx in S_IRQ, pulse rstn low asynchronously (not clock-aligned) -> all outputs at reset values immediately; no stale bytes appear after release.

Source files
------------

// File: rtl/io_peripheral_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_periph_pkg
// Description : Shared types and constants for the external-side I/O
//               controller (rx state encoding, data width, clog2 helper).
// Revision    : 1.0 - initial release
// ============================================================================
package io_periph_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_IRQ   = 2'd1,
        S_WAIT  = 2'd2
    } rx_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_peripheral_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : io_periph_if
// Description : Bundle of CPU-port and external-device signals seen by the
//               I/O controller. The controller uses the slave view; the
//               CPU / external device side uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_periph_if;
    import io_periph_pkg::*;

    // CPU side
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_out_we;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_ack;
    logic              int_sig;
    logic              int_enable;
    // External device side
    logic [DATA_W-1:0] ext_tx_data;
    logic              ext_tx_valid;
    logic              ext_tx_ready;
    logic [DATA_W-1:0] ext_rx_data;
    logic              ext_rx_valid;
    logic              ext_rx_ready;
    // Status
    logic              rx_full;
    logic              tx_overflow;

    modport master (
        output cpu_out_data, cpu_out_we, cpu_in_ack, int_enable,
               ext_tx_ready, ext_rx_data, ext_rx_valid,
        input  cpu_in_data, int_sig, ext_tx_data, ext_tx_valid,
               ext_rx_ready, rx_full, tx_overflow
    );

    modport slave (
        input  cpu_out_data, cpu_out_we, cpu_in_ack, int_enable,
               ext_tx_ready, ext_rx_data, ext_rx_valid,
        output cpu_in_data, int_sig, ext_tx_data, ext_tx_valid,
               ext_rx_ready, rx_full, tx_overflow
    );

endinterface
`default_nettype wire

// File: rtl/io_peripheral_ctrl_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_tx_fifo
// Description : Synchronous FIFO with extra-MSB pointers and a registered
//               head output. The head register is loaded with the entry that
//               will be at the front after each edge, so data is valid the
//               cycle after a write into an empty FIFO and never changes
//               while the head is not popped.
// Revision    : 1.0 - initial release
// ============================================================================
module io_tx_fifo
    import io_periph_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Occupancy flags from pointer compare: same index, MSB differs => full.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rdata_o = head_q;
    end

    // Next pointers and next head; head is held while the FIFO stays empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        head_d   = head_q;
        if (rd_ptr_d != wr_ptr_d) begin
            if (push_i && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Pointer and head registers; reset discards all queued entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_peripheral_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_peripheral_ctrl
// Description : External-side I/O controller. CPU output writes are queued in
//               a TX FIFO and drained over a valid/ready handshake; received
//               bytes are held for the CPU input port, with an interrupt
//               pulse per byte and back-pressure until the CPU acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module io_peripheral_ctrl
    import io_periph_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int INT_PULSE_CYC = 2
) (
    input  wire logic clk,
    input  wire logic rstn,
    io_periph_if.slave bus
);

    localparam int            CNT_W    = (clog2(INT_PULSE_CYC + 1) < 1) ? 1 : clog2(INT_PULSE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INT_PULSE_CYC - 1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_head;
    logic              tx_overflow_q, tx_overflow_d;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted when the head is leaving.
    always_comb begin
        tx_pop        = !tx_empty && bus.ext_tx_ready;
        tx_push       = bus.cpu_out_we && (!tx_full || tx_pop);
        tx_overflow_d = tx_overflow_q || (bus.cpu_out_we && tx_full && !tx_pop);
    end

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (tx_push),
        .wdata_i (bus.cpu_out_data),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .rdata_o (tx_head)
    );

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_overflow_q <= 1'b0;
        end else begin
            tx_overflow_q <= tx_overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  irq_cnt_q, irq_cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    // RX state register with captured byte and pulse counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q <= S_EMPTY;
            irq_cnt_q  <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            irq_cnt_q  <= irq_cnt_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // RX next-state: capture when empty, pulse the interrupt, wait for ack.
    always_comb begin
        rx_state_d = rx_state_q;
        irq_cnt_d  = irq_cnt_q;
        rx_data_d  = rx_data_q;
        case (rx_state_q)
            S_EMPTY: begin
                if (bus.ext_rx_valid) begin
                    rx_data_d  = bus.ext_rx_data;
                    irq_cnt_d  = '0;
                    rx_state_d = bus.int_enable ? S_IRQ : S_WAIT;
                end
            end
            S_IRQ: begin
                // An early ack ends the pulse and frees the holding register.
                if (bus.cpu_in_ack) begin
                    rx_state_d = S_EMPTY;
                end else if (irq_cnt_q == CNT_LAST) begin
                    rx_state_d = S_WAIT;
                end else begin
                    irq_cnt_d = irq_cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.cpu_in_ack) begin
                    rx_state_d = S_EMPTY;
                end
            end
            default: begin
                rx_state_d = S_EMPTY;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.int_sig      = (rx_state_q == S_IRQ);
        bus.ext_rx_ready = (rx_state_q == S_EMPTY);
        bus.rx_full      = (rx_state_q != S_EMPTY);
        bus.cpu_in_data  = rx_data_q;
        bus.ext_tx_valid = !tx_empty;
        bus.ext_tx_data  = tx_head;
        bus.tx_overflow  = tx_overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_io_peripheral_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_peripheral_ctrl
// Description : Scoreboard bench for io_peripheral_ctrl. Stimulus is applied
//               on falling edges and a behavioural model predicts outputs;
//               a monitor compares on the falling edge + 1 time unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_peripheral_ctrl;

    localparam int DEPTH = 4;
    localparam int PULSE = 2;

    logic clk;
    logic rstn;

    io_periph_if bus ();

    io_peripheral_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .INT_PULSE_CYC (PULSE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state (value after the most recent clock edge)
    int         m_cnt;
    bit         m_ovf;
    bit         m_busy;
    int         m_irq_left;
    logic [7:0] m_held;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    // Expected outputs for the current cycle
    logic       exp_tx_valid, exp_ovf, exp_int, exp_full, exp_rdy;
    logic [7:0] exp_rxd;

    bit mon_en = 0;
    bit prev_full = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_cnt = 0; m_ovf = 0; m_busy = 0; m_irq_left = 0; m_held = 8'h00;
        tx_exp.delete();
        rx_exp.delete();
        prev_full = 0;
    endfunction

    // One cycle of stimulus; also advances the reference model to the next edge.
    task automatic drive(input logic we, input logic [7:0] d, input logic rdy,
                         input logic rv, input logic [7:0] rd, input logic ack,
                         input logic ien);
        bit pop;
        @(negedge clk);
        exp_tx_valid = (m_cnt > 0);
        exp_ovf      = m_ovf;
        exp_int      = (m_irq_left > 0);
        exp_full     = m_busy;
        exp_rdy      = !m_busy;
        exp_rxd      = m_held;
        bus.cpu_out_we   = we;
        bus.cpu_out_data = d;
        bus.ext_tx_ready = rdy;
        bus.ext_rx_valid = rv;
        bus.ext_rx_data  = rd;
        bus.cpu_in_ack   = ack;
        bus.int_enable   = ien;
        // TX rules
        pop = (m_cnt > 0) && rdy;
        if (we) begin
            if (m_cnt < DEPTH || pop) begin
                tx_exp.push_back(d);
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_cnt--;
        // RX rules
        if (!m_busy) begin
            if (rv) begin
                m_busy     = 1;
                m_held     = rd;
                m_irq_left = ien ? PULSE : 0;
                rx_exp.push_back(rd);
            end
        end else if (ack) begin
            m_busy     = 0;
            m_irq_left = 0;
        end else if (m_irq_left > 0) begin
            m_irq_left--;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, rdy, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted and released away from the rising edge.
    task automatic async_reset();
        idle(1, 1'b0);
        #3;
        mon_en = 0;
        rstn = 1'b0;
        #1;
        check("rst_tx_valid",    32'(bus.ext_tx_valid), 32'h0);
        check("rst_tx_data",     32'(bus.ext_tx_data),  32'h0);
        check("rst_tx_overflow", 32'(bus.tx_overflow),  32'h0);
        check("rst_int_sig",     32'(bus.int_sig),      32'h0);
        check("rst_rx_full",     32'(bus.rx_full),      32'h0);
        check("rst_rx_ready",    32'(bus.ext_rx_ready), 32'h1);
        check("rst_cpu_in_data", 32'(bus.cpu_in_data),  32'h0);
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b1;
        mon_en = 1;
    endtask

    // Monitor: compares DUT outputs with the model and pops scoreboards.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("tx_valid",    32'(bus.ext_tx_valid), 32'(exp_tx_valid));
                check("tx_overflow", 32'(bus.tx_overflow),  32'(exp_ovf));
                check("int_sig",     32'(bus.int_sig),      32'(exp_int));
                check("rx_full",     32'(bus.rx_full),      32'(exp_full));
                check("rx_ready",    32'(bus.ext_rx_ready), 32'(exp_rdy));
                check("cpu_in_data", 32'(bus.cpu_in_data),  32'(exp_rxd));
                if (bus.ext_tx_valid === 1'b1) begin
                    if (tx_exp.size() == 0) begin
                        check("tx_unexpected", 32'(bus.ext_tx_data), 32'hFFFF_FFFF);
                    end else begin
                        check("tx_data", 32'(bus.ext_tx_data), 32'(tx_exp[0]));
                        if (bus.ext_tx_ready) void'(tx_exp.pop_front());
                    end
                end
                if (bus.rx_full === 1'b1 && !prev_full) begin
                    if (rx_exp.size() == 0) begin
                        check("rx_unexpected", 32'(bus.cpu_in_data), 32'hFFFF_FFFF);
                    end else begin
                        check("rx_capture", 32'(bus.cpu_in_data), 32'(rx_exp.pop_front()));
                    end
                end
                prev_full = (bus.rx_full === 1'b1);
            end
        end
    end

    initial begin
        rstn = 1'b1;
        bus.cpu_out_we = 0; bus.cpu_out_data = 0; bus.ext_tx_ready = 0;
        bus.ext_rx_valid = 0; bus.ext_rx_data = 0; bus.cpu_in_ack = 0;
        bus.int_enable = 0;
        model_clear();
        async_reset();

        // TX basic with ready held high
        drive(1, 8'h11, 1, 0, 0, 0, 0);
        drive(1, 8'h22, 1, 0, 0, 0, 0);
        drive(1, 8'h33, 1, 0, 0, 0, 0);
        idle(3, 1'b1);

        // TX overflow: five writes into a four-entry FIFO with ready low
        for (int i = 1; i <= 5; i++) drive(1, 8'(i), 0, 0, 0, 0, 0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Full FIFO with simultaneous pop accepts the write
        async_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, 8'hA0 + 8'(i), 0, 0, 0, 0, 0);
        drive(1, 8'hAA, 1, 0, 0, 0, 0);
        idle(6, 1'b1);

        // RX with interrupt pulse, then ack
        drive(0, 0, 0, 1, 8'h5C, 0, 1);
        idle(3, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(2, 1'b0);

        // RX back-pressure: byte held off while waiting for ack
        drive(0, 0, 0, 1, 8'h12, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 8'h77, 0, 0);
        drive(0, 0, 0, 1, 8'h77, 1, 0);
        drive(0, 0, 0, 1, 8'h77, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0);   // early ack in the pulse
        idle(2, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(1, 1'b0);

        // Reset mid-operation: three queued bytes and an interrupt pulse
        drive(1, 8'hC1, 0, 0, 0, 0, 0);
        drive(1, 8'hC2, 0, 0, 0, 0, 0);
        drive(1, 8'hC3, 0, 1, 8'h9E, 0, 1);
        async_reset();
        idle(4, 1'b1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic rdy;
            rdy = (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom), rdy,
                  1'($urandom_range(0, 2) == 0), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if (i % 500 == 499) async_reset();
        end

        // Drain and release everything
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 0, 0, 1, 0);
        idle(2, 1'b1);
        mon_en = 0;
        check("tx_drained", 32'(tx_exp.size()), 32'h0);
        check("rx_drained", 32'(rx_exp.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
